// File: rtl/tl_pkg.sv
// TileLink-UL opcode constants and target encoding shared by the peripheral demux.
package tl_pkg;

  localparam logic [2:0] TL_PUT_FULL        = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] TL_ARITH           = 3'd2;
  localparam logic [2:0] TL_LOGIC           = 3'd3;
  localparam logic [2:0] TL_GET             = 3'd4;
  localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

  // CLINT occupies a fixed 64 KiB window.
  localparam logic [31:0] CLINT_BASE_DEF = 32'h0200_0000;
  localparam int          CLINT_WIN_W    = 16;

  typedef enum logic [1:0] {
    TGT_CLINT  = 2'd0,
    TGT_PERIPH = 2'd1,
    TGT_ERR    = 2'd2
  } tgt_e;

  function automatic logic [2:0] err_d_opcode(input logic [2:0] a_opcode);
    return (a_opcode == TL_GET) ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
  endfunction

endpackage

// File: rtl/tl_err_responder.sv
// Single-entry responder that answers unmapped requests with a denied
// AccessAck / AccessAckData.
module tl_err_responder
  import tl_pkg::*;
#(
  parameter int TL_RS = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [2:0]       a_opcode,
  input  logic [3:0]       a_size,
  input  logic [TL_RS-1:0] a_source,
  output logic             d_valid,
  input  logic             d_ready,
  output logic [2:0]       d_opcode,
  output logic [1:0]       d_param,
  output logic [3:0]       d_size,
  output logic [TL_RS-1:0] d_source,
  output logic             d_denied,
  output logic [31:0]      d_data,
  output logic             d_corrupt
);

  logic             err_valid_reg;
  logic [2:0]       opcode_reg;
  logic [3:0]       size_reg;
  logic [TL_RS-1:0] source_reg;

  assign a_ready = ~err_valid_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      err_valid_reg <= 1'b0;
    end else if (a_valid & a_ready) begin
      err_valid_reg <= 1'b1;
    end else if (d_valid & d_ready) begin
      err_valid_reg <= 1'b0;
    end
  end

  // Payload needs no reset: it is only observed while err_valid_reg is set.
  always_ff @(posedge clk) begin
    if (a_valid & a_ready) begin
      opcode_reg <= a_opcode;
      size_reg   <= a_size;
      source_reg <= a_source;
    end
  end

  assign d_valid   = err_valid_reg;
  assign d_opcode  = err_d_opcode(opcode_reg);
  assign d_param   = 2'd0;
  assign d_size    = size_reg;
  assign d_source  = source_reg;
  assign d_denied  = 1'b1;
  assign d_data    = 32'd0;
  assign d_corrupt = (opcode_reg == TL_GET);

endmodule

// File: rtl/tl_periph_demux.sv
// TileLink-UL 1-to-2 address demux in front of the CLINT and one peripheral,
// with an internal denied responder for unmapped addresses.
module tl_periph_demux
  import tl_pkg::*;
#(
  parameter int          TL_RS         = 4,
  parameter logic [31:0] CLINT_BASE    = CLINT_BASE_DEF,
  parameter logic [31:0] PERIPH_BASE   = 32'h1000_0000,
  parameter int          PERIPH_ADDR_W = 16,
  parameter int          MAX_OUT       = 4
) (
  input  logic                     xbar_clock_i,
  input  logic                     xbar_reset_i,

  input  logic [2:0]               host_a_opcode,
  input  logic [2:0]               host_a_param,
  input  logic [3:0]               host_a_size,
  input  logic [TL_RS-1:0]         host_a_source,
  input  logic [31:0]              host_a_address,
  input  logic [3:0]               host_a_mask,
  input  logic [31:0]              host_a_data,
  input  logic                     host_a_corrupt,
  input  logic                     host_a_valid,
  output logic                     host_a_ready,

  output logic [2:0]               host_d_opcode,
  output logic [1:0]               host_d_param,
  output logic [3:0]               host_d_size,
  output logic [TL_RS-1:0]         host_d_source,
  output logic                     host_d_denied,
  output logic [31:0]              host_d_data,
  output logic                     host_d_corrupt,
  output logic                     host_d_valid,
  input  logic                     host_d_ready,

  output logic [2:0]               clint_a_opcode,
  output logic [2:0]               clint_a_param,
  output logic [3:0]               clint_a_size,
  output logic [TL_RS-1:0]         clint_a_source,
  output logic [15:0]              clint_a_address,
  output logic [3:0]               clint_a_mask,
  output logic [31:0]              clint_a_data,
  output logic                     clint_a_corrupt,
  output logic                     clint_a_valid,
  input  logic                     clint_a_ready,

  input  logic [2:0]               clint_d_opcode,
  input  logic [1:0]               clint_d_param,
  input  logic [3:0]               clint_d_size,
  input  logic [TL_RS-1:0]         clint_d_source,
  input  logic                     clint_d_denied,
  input  logic [31:0]              clint_d_data,
  input  logic                     clint_d_corrupt,
  input  logic                     clint_d_valid,
  output logic                     clint_d_ready,

  output logic [2:0]               periph_a_opcode,
  output logic [2:0]               periph_a_param,
  output logic [3:0]               periph_a_size,
  output logic [TL_RS-1:0]         periph_a_source,
  output logic [PERIPH_ADDR_W-1:0] periph_a_address,
  output logic [3:0]               periph_a_mask,
  output logic [31:0]              periph_a_data,
  output logic                     periph_a_corrupt,
  output logic                     periph_a_valid,
  input  logic                     periph_a_ready,

  input  logic [2:0]               periph_d_opcode,
  input  logic [1:0]               periph_d_param,
  input  logic [3:0]               periph_d_size,
  input  logic [TL_RS-1:0]         periph_d_source,
  input  logic                     periph_d_denied,
  input  logic [31:0]              periph_d_data,
  input  logic                     periph_d_corrupt,
  input  logic                     periph_d_valid,
  output logic                     periph_d_ready
);

  localparam int            CW        = $clog2(MAX_OUT) + 1;
  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);
  localparam int            NSLV      = 2;

  tgt_e          tgt;
  tgt_e          cur_tgt_reg, cur_tgt_next;
  logic [CW-1:0] out_cnt_reg, out_cnt_next;
  logic [1:0]    tgt_idx, cur_idx;
  logic          cnt_nz, stall, sel_a_ready, sel_d_valid;
  logic          a_fire, d_fire;

  logic [NSLV-1:0] slv_a_valid, slv_d_ready;

  logic             err_a_valid, err_a_ready, err_d_valid, err_d_ready;
  logic [2:0]       err_d_opcode_w;
  logic [1:0]       err_d_param;
  logic [3:0]       err_d_size;
  logic [TL_RS-1:0] err_d_source;
  logic             err_d_denied, err_d_corrupt;
  logic [31:0]      err_d_data;

  // CLINT wins if the two windows were ever configured to overlap.
  always_comb begin
    tgt = TGT_ERR;
    if (host_a_address[31:CLINT_WIN_W] == CLINT_BASE[31:CLINT_WIN_W]) begin
      tgt = TGT_CLINT;
    end else if (host_a_address[31:PERIPH_ADDR_W] == PERIPH_BASE[31:PERIPH_ADDR_W]) begin
      tgt = TGT_PERIPH;
    end
  end

  assign tgt_idx = tgt;
  assign cur_idx = cur_tgt_reg;
  assign cnt_nz  = (out_cnt_reg != '0);

  // Only one target may be in flight at a time, which keeps responses ordered.
  assign stall = (out_cnt_reg == MAX_OUT_C)
               | (cnt_nz & (tgt != cur_tgt_reg))
               | ((tgt == TGT_ERR) & ~err_a_ready);

  always_comb begin
    sel_a_ready = err_a_ready;
    case (tgt)
      TGT_CLINT:  sel_a_ready = clint_a_ready;
      TGT_PERIPH: sel_a_ready = periph_a_ready;
      default:    ;
    endcase
  end

  assign host_a_ready = ~stall & sel_a_ready;
  assign err_a_valid  = host_a_valid & (tgt == TGT_ERR) & ~stall;

  for (genvar gi = 0; gi < NSLV; gi++) begin : g_slv
    assign slv_a_valid[gi] = host_a_valid & (tgt_idx == 2'(gi)) & ~stall;
    assign slv_d_ready[gi] = host_d_ready & (cur_idx == 2'(gi)) & cnt_nz;
  end

  assign clint_a_valid  = slv_a_valid[0];
  assign periph_a_valid = slv_a_valid[1];
  assign clint_d_ready  = slv_d_ready[0];
  assign periph_d_ready = slv_d_ready[1];
  assign err_d_ready    = host_d_ready & (cur_tgt_reg == TGT_ERR) & cnt_nz;

  assign clint_a_opcode   = host_a_opcode;
  assign clint_a_param    = host_a_param;
  assign clint_a_size     = host_a_size;
  assign clint_a_source   = host_a_source;
  assign clint_a_address  = host_a_address[CLINT_WIN_W-1:0];
  assign clint_a_mask     = host_a_mask;
  assign clint_a_data     = host_a_data;
  assign clint_a_corrupt  = host_a_corrupt;

  assign periph_a_opcode  = host_a_opcode;
  assign periph_a_param   = host_a_param;
  assign periph_a_size    = host_a_size;
  assign periph_a_source  = host_a_source;
  assign periph_a_address = host_a_address[PERIPH_ADDR_W-1:0];
  assign periph_a_mask    = host_a_mask;
  assign periph_a_data    = host_a_data;
  assign periph_a_corrupt = host_a_corrupt;

  always_comb begin
    sel_d_valid    = err_d_valid;
    host_d_opcode  = err_d_opcode_w;
    host_d_param   = err_d_param;
    host_d_size    = err_d_size;
    host_d_source  = err_d_source;
    host_d_denied  = err_d_denied;
    host_d_data    = err_d_data;
    host_d_corrupt = err_d_corrupt;
    case (cur_tgt_reg)
      TGT_CLINT: begin
        sel_d_valid    = clint_d_valid;
        host_d_opcode  = clint_d_opcode;
        host_d_param   = clint_d_param;
        host_d_size    = clint_d_size;
        host_d_source  = clint_d_source;
        host_d_denied  = clint_d_denied;
        host_d_data    = clint_d_data;
        host_d_corrupt = clint_d_corrupt;
      end
      TGT_PERIPH: begin
        sel_d_valid    = periph_d_valid;
        host_d_opcode  = periph_d_opcode;
        host_d_param   = periph_d_param;
        host_d_size    = periph_d_size;
        host_d_source  = periph_d_source;
        host_d_denied  = periph_d_denied;
        host_d_data    = periph_d_data;
        host_d_corrupt = periph_d_corrupt;
      end
      default: ;
    endcase
  end

  assign host_d_valid = sel_d_valid & cnt_nz;

  assign a_fire = host_a_valid & host_a_ready;
  assign d_fire = host_d_valid & host_d_ready;

  always_comb begin
    out_cnt_next = out_cnt_reg;
    cur_tgt_next = cur_tgt_reg;
    if (a_fire) begin
      cur_tgt_next = tgt;
    end
    case ({a_fire, d_fire})
      2'b10:   out_cnt_next = out_cnt_reg + CW'(1);
      2'b01:   out_cnt_next = out_cnt_reg - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge xbar_clock_i) begin
    if (xbar_reset_i) begin
      out_cnt_reg <= '0;
      cur_tgt_reg <= TGT_CLINT;
    end else begin
      out_cnt_reg <= out_cnt_next;
      cur_tgt_reg <= cur_tgt_next;
    end
  end

  tl_err_responder #(
    .TL_RS(TL_RS)
  ) u_err (
    .clk       (xbar_clock_i),
    .srst      (xbar_reset_i),
    .a_valid   (err_a_valid),
    .a_ready   (err_a_ready),
    .a_opcode  (host_a_opcode),
    .a_size    (host_a_size),
    .a_source  (host_a_source),
    .d_valid   (err_d_valid),
    .d_ready   (err_d_ready),
    .d_opcode  (err_d_opcode_w),
    .d_param   (err_d_param),
    .d_size    (err_d_size),
    .d_source  (err_d_source),
    .d_denied  (err_d_denied),
    .d_data    (err_d_data),
    .d_corrupt (err_d_corrupt)
  );

endmodule

// File: tb/tb_tl_periph_demux.sv
// Directed bench for tl_periph_demux: a request-queue model checks every cycle,
// and literal checks pin the key scenarios.
module tb_tl_periph_demux;

  localparam int TL_RS   = 4;
  localparam int MAX_OUT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]  host_a_opcode, host_a_param;
  logic [3:0]  host_a_size, host_a_mask;
  logic [TL_RS-1:0] host_a_source;
  logic [31:0] host_a_address, host_a_data;
  logic        host_a_corrupt, host_a_valid, host_a_ready;
  logic [2:0]  host_d_opcode;
  logic [1:0]  host_d_param;
  logic [3:0]  host_d_size;
  logic [TL_RS-1:0] host_d_source;
  logic        host_d_denied, host_d_corrupt, host_d_valid, host_d_ready;
  logic [31:0] host_d_data;

  logic [2:0]  clint_a_opcode, clint_a_param;
  logic [3:0]  clint_a_size, clint_a_mask;
  logic [TL_RS-1:0] clint_a_source;
  logic [15:0] clint_a_address;
  logic [31:0] clint_a_data;
  logic        clint_a_corrupt, clint_a_valid, clint_a_ready;
  logic [2:0]  clint_d_opcode;
  logic [1:0]  clint_d_param;
  logic [3:0]  clint_d_size;
  logic [TL_RS-1:0] clint_d_source;
  logic        clint_d_denied, clint_d_corrupt, clint_d_valid, clint_d_ready;
  logic [31:0] clint_d_data;

  logic [2:0]  periph_a_opcode, periph_a_param;
  logic [3:0]  periph_a_size, periph_a_mask;
  logic [TL_RS-1:0] periph_a_source;
  logic [15:0] periph_a_address;
  logic [31:0] periph_a_data;
  logic        periph_a_corrupt, periph_a_valid, periph_a_ready;
  logic [2:0]  periph_d_opcode;
  logic [1:0]  periph_d_param;
  logic [3:0]  periph_d_size;
  logic [TL_RS-1:0] periph_d_source;
  logic        periph_d_denied, periph_d_corrupt, periph_d_valid, periph_d_ready;
  logic [31:0] periph_d_data;

  tl_periph_demux dut (
    .xbar_clock_i(clk), .xbar_reset_i(rst),
    .host_a_opcode(host_a_opcode), .host_a_param(host_a_param), .host_a_size(host_a_size),
    .host_a_source(host_a_source), .host_a_address(host_a_address), .host_a_mask(host_a_mask),
    .host_a_data(host_a_data), .host_a_corrupt(host_a_corrupt), .host_a_valid(host_a_valid),
    .host_a_ready(host_a_ready),
    .host_d_opcode(host_d_opcode), .host_d_param(host_d_param), .host_d_size(host_d_size),
    .host_d_source(host_d_source), .host_d_denied(host_d_denied), .host_d_data(host_d_data),
    .host_d_corrupt(host_d_corrupt), .host_d_valid(host_d_valid), .host_d_ready(host_d_ready),
    .clint_a_opcode(clint_a_opcode), .clint_a_param(clint_a_param), .clint_a_size(clint_a_size),
    .clint_a_source(clint_a_source), .clint_a_address(clint_a_address), .clint_a_mask(clint_a_mask),
    .clint_a_data(clint_a_data), .clint_a_corrupt(clint_a_corrupt), .clint_a_valid(clint_a_valid),
    .clint_a_ready(clint_a_ready),
    .clint_d_opcode(clint_d_opcode), .clint_d_param(clint_d_param), .clint_d_size(clint_d_size),
    .clint_d_source(clint_d_source), .clint_d_denied(clint_d_denied), .clint_d_data(clint_d_data),
    .clint_d_corrupt(clint_d_corrupt), .clint_d_valid(clint_d_valid), .clint_d_ready(clint_d_ready),
    .periph_a_opcode(periph_a_opcode), .periph_a_param(periph_a_param), .periph_a_size(periph_a_size),
    .periph_a_source(periph_a_source), .periph_a_address(periph_a_address), .periph_a_mask(periph_a_mask),
    .periph_a_data(periph_a_data), .periph_a_corrupt(periph_a_corrupt), .periph_a_valid(periph_a_valid),
    .periph_a_ready(periph_a_ready),
    .periph_d_opcode(periph_d_opcode), .periph_d_param(periph_d_param), .periph_d_size(periph_d_size),
    .periph_d_source(periph_d_source), .periph_d_denied(periph_d_denied), .periph_d_data(periph_d_data),
    .periph_d_corrupt(periph_d_corrupt), .periph_d_valid(periph_d_valid), .periph_d_ready(periph_d_ready)
  );

  typedef struct {
    int               tgt;
    logic [TL_RS-1:0] src;
    logic [2:0]       op;
    logic [3:0]       size;
  } req_t;

  req_t q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endfunction

  // 0 = CLINT, 1 = peripheral, 2 = unmapped
  function automatic int decode(logic [31:0] a);
    if (a >= 32'h0200_0000 && a < 32'h0201_0000) return 0;
    if (a >= 32'h1000_0000 && a < 32'h1001_0000) return 1;
    return 2;
  endfunction

  logic exp_a_fire = 1'b0;
  logic exp_d_fire = 1'b0;
  req_t exp_new;
  int   m_t, m_hd;
  bit   m_busy, m_has_err, m_stall, m_sel_rdy, m_a_ready, m_d_valid;

  always @(negedge clk) begin
    exp_a_fire = 1'b0;
    exp_d_fire = 1'b0;
    if (!rst) begin
      m_t       = decode(host_a_address);
      m_busy    = (q.size() != 0);
      m_hd      = m_busy ? q[0].tgt : 0;
      m_has_err = 1'b0;
      foreach (q[i]) if (q[i].tgt == 2) m_has_err = 1'b1;
      m_stall   = (q.size() == MAX_OUT) || (m_busy && m_t != q[q.size()-1].tgt) ||
                  (m_t == 2 && m_has_err);
      m_sel_rdy = (m_t == 0) ? clint_a_ready : (m_t == 1) ? periph_a_ready : !m_has_err;
      m_a_ready = !m_stall && m_sel_rdy;
      m_d_valid = m_busy && ((m_hd == 0) ? clint_d_valid : (m_hd == 1) ? periph_d_valid : 1'b1);

      chk("host_a_ready", host_a_ready, m_a_ready);
      chk("clint_a_valid", clint_a_valid, host_a_valid && m_t == 0 && !m_stall);
      chk("periph_a_valid", periph_a_valid, host_a_valid && m_t == 1 && !m_stall);
      chk("host_d_valid", host_d_valid, m_d_valid);
      chk("clint_d_ready", clint_d_ready, host_d_ready && m_busy && m_hd == 0);
      chk("periph_d_ready", periph_d_ready, host_d_ready && m_busy && m_hd == 1);
      chk("clint_a_address", clint_a_address, host_a_address[15:0]);
      chk("periph_a_address", periph_a_address, host_a_address[15:0]);
      chk("clint_a_data", clint_a_data, host_a_data);
      chk("periph_a_source", periph_a_source, host_a_source);

      if (m_d_valid) begin
        if (m_hd == 2) begin
          chk("err_d_opcode", host_d_opcode, (q[0].op == 3'd4) ? 3'd1 : 3'd0);
          chk("err_d_corrupt", host_d_corrupt, q[0].op == 3'd4);
          chk("err_d_denied", host_d_denied, 1'b1);
          chk("err_d_data", host_d_data, 32'd0);
          chk("err_d_param", host_d_param, 2'd0);
          chk("err_d_source", host_d_source, q[0].src);
          chk("err_d_size", host_d_size, q[0].size);
        end else if (m_hd == 0) begin
          chk("d_opcode_c", host_d_opcode, clint_d_opcode);
          chk("d_source_c", host_d_source, clint_d_source);
          chk("d_data_c", host_d_data, clint_d_data);
          chk("d_denied_c", host_d_denied, clint_d_denied);
        end else begin
          chk("d_opcode_p", host_d_opcode, periph_d_opcode);
          chk("d_source_p", host_d_source, periph_d_source);
          chk("d_data_p", host_d_data, periph_d_data);
          chk("d_denied_p", host_d_denied, periph_d_denied);
        end
      end

      exp_a_fire   = host_a_valid && m_a_ready;
      exp_d_fire   = m_d_valid && host_d_ready;
      exp_new.tgt  = m_t;
      exp_new.src  = host_a_source;
      exp_new.op   = host_a_opcode;
      exp_new.size = host_a_size;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (exp_d_fire) begin
        $display("D resp: tgt=%0d src=%0d op=%0d", q[0].tgt, q[0].src, q[0].op);
        void'(q.pop_front());
      end
      if (exp_a_fire) begin
        q.push_back(exp_new);
        $display("A req : tgt=%0d src=%0d op=%0d addr=%h", exp_new.tgt, exp_new.src,
                 exp_new.op, host_a_address);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic a_req(input logic [31:0] addr, input logic [2:0] op, input logic [TL_RS-1:0] src,
                       input logic [31:0] data);
    host_a_valid   = 1'b1;
    host_a_address = addr;
    host_a_opcode  = op;
    host_a_param   = 3'd0;
    host_a_size    = 4'd2;
    host_a_source  = src;
    host_a_mask    = 4'hF;
    host_a_data    = data;
    host_a_corrupt = 1'b0;
  endtask

  task automatic clint_rsp(input logic v, input logic [2:0] op, input logic [TL_RS-1:0] src,
                           input logic [31:0] data);
    clint_d_valid = v; clint_d_opcode = op; clint_d_source = src; clint_d_data = data;
    clint_d_param = 2'd0; clint_d_size = 4'd2; clint_d_denied = 1'b0; clint_d_corrupt = 1'b0;
  endtask

  task automatic periph_rsp(input logic v, input logic [2:0] op, input logic [TL_RS-1:0] src,
                            input logic [31:0] data);
    periph_d_valid = v; periph_d_opcode = op; periph_d_source = src; periph_d_data = data;
    periph_d_param = 2'd0; periph_d_size = 4'd2; periph_d_denied = 1'b0; periph_d_corrupt = 1'b0;
  endtask

  logic [31:0] dec_addr [8] = '{32'h0200_0000, 32'h0200_FFFF, 32'h0201_0000, 32'h01FF_FFFC,
                                32'h1000_0000, 32'h1000_FFFF, 32'h1001_0000, 32'h0000_0000};
  int          dec_tgt  [8] = '{0, 0, 2, 2, 1, 1, 2, 2};

  initial begin
    rst = 1'b1;
    a_req(32'h0, 3'd4, '0, '0);
    host_a_valid  = 1'b0;
    host_d_ready  = 1'b0;
    clint_a_ready = 1'b0;
    periph_a_ready = 1'b0;
    clint_rsp(1'b0, 3'd0, '0, '0);
    periph_rsp(1'b0, 3'd0, '0, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    a_req(32'h0200_0000, 3'd4, 4'd0, 32'd0);
    clint_a_ready = 1'b1; host_d_ready = 1'b1; settle();
    chk("rst_a_ready_follows_clint", host_a_ready, 1'b1);
    chk("rst_d_valid", host_d_valid, 1'b0);
    chk("rst_clint_d_ready", clint_d_ready, 1'b0);
    clint_a_ready = 1'b0; settle();
    chk("rst_a_ready_clint_busy", host_a_ready, 1'b0);
    host_a_valid = 1'b0; host_d_ready = 1'b0;

    // address decode boundaries, never firing
    clint_a_ready = 1'b1; periph_a_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      nxt();
      a_req(dec_addr[i], 3'd4, 4'd1, 32'd0); settle();
      chk("dec_clint_valid", clint_a_valid, dec_tgt[i] == 0);
      chk("dec_periph_valid", periph_a_valid, dec_tgt[i] == 1);
      chk("dec_a_ready", host_a_ready, 1'b1);
      host_a_valid = 1'b0;
    end

    // CLINT Get
    nxt();
    a_req(32'h0200_BFF8, 3'd4, 4'd3, 32'd0); settle();
    chk("t1_clint_a_valid", clint_a_valid, 1'b1);
    chk("t1_clint_a_address", clint_a_address, 16'hBFF8);
    nxt();
    host_a_valid = 1'b0; host_d_ready = 1'b1;
    clint_rsp(1'b1, 3'd1, 4'd3, 32'h1234); settle();
    chk("t1_d_valid", host_d_valid, 1'b1);
    chk("t1_d_opcode", host_d_opcode, 3'd1);
    chk("t1_d_data", host_d_data, 32'h1234);
    chk("t1_d_denied", host_d_denied, 1'b0);
    nxt();
    clint_rsp(1'b0, 3'd0, '0, '0); settle();
    chk("t1_d_idle", host_d_valid, 1'b0);

    // peripheral PutFull then an atomic passed through untouched
    a_req(32'h1000_0010, 3'd0, 4'd7, 32'hDEAD_BEEF); settle();
    chk("t2_periph_a_valid", periph_a_valid, 1'b1);
    chk("t2_clint_a_valid", clint_a_valid, 1'b0);
    chk("t2_periph_a_data", periph_a_data, 32'hDEAD_BEEF);
    nxt();
    host_a_valid = 1'b0;
    periph_rsp(1'b1, 3'd0, 4'd7, 32'd0); settle();
    chk("t2_d_source", host_d_source, 4'd7);
    chk("t2_d_opcode", host_d_opcode, 3'd0);
    nxt();
    periph_rsp(1'b0, 3'd0, '0, '0);
    a_req(32'h1000_0020, 3'd2, 4'd9, 32'h5); host_a_param = 3'd3; settle();
    chk("t2_arith_opcode", periph_a_opcode, 3'd2);
    chk("t2_arith_param", periph_a_param, 3'd3);
    nxt();
    host_a_valid = 1'b0;
    periph_rsp(1'b1, 3'd1, 4'd9, 32'h55); settle();
    chk("t2_arith_d_data", host_d_data, 32'h55);
    nxt();
    periph_rsp(1'b0, 3'd0, '0, '0);

    // unmapped Get, then an unmapped PutFull stuck behind it
    a_req(32'h3000_0000, 3'd4, 4'd5, 32'd0); host_d_ready = 1'b0; settle();
    chk("t3_a_ready", host_a_ready, 1'b1);
    chk("t3_no_slave_valid", clint_a_valid | periph_a_valid, 1'b0);
    nxt();
    a_req(32'h3000_0004, 3'd0, 4'd6, 32'd0); settle();
    chk("t3_d_valid", host_d_valid, 1'b1);
    chk("t3_d_opcode", host_d_opcode, 3'd1);
    chk("t3_d_denied", host_d_denied, 1'b1);
    chk("t3_d_corrupt", host_d_corrupt, 1'b1);
    chk("t3_d_data", host_d_data, 32'd0);
    chk("t3_d_source", host_d_source, 4'd5);
    chk("t3_second_stalled", host_a_ready, 1'b0);
    nxt();
    host_d_ready = 1'b1; settle();
    chk("t3_stall_during_dfire", host_a_ready, 1'b0);
    nxt(); settle();
    chk("t3_second_accepted", host_a_ready, 1'b1);
    nxt();
    host_a_valid = 1'b0; settle();
    chk("t3_put_d_opcode", host_d_opcode, 3'd0);
    chk("t3_put_d_corrupt", host_d_corrupt, 1'b0);
    chk("t3_put_d_source", host_d_source, 4'd6);
    nxt(); settle();
    chk("t3_d_idle", host_d_valid, 1'b0);

    // fill to MAX_OUT, then overlap an A fire with a D fire
    host_d_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nxt();
      a_req(32'h0200_0000 + 32'(4 * i), 3'd4, 4'(i), 32'd0); settle();
      chk("t4_fill_ready", host_a_ready, 1'b1);
    end
    nxt();
    a_req(32'h0200_0040, 3'd4, 4'd4, 32'd0); settle();
    chk("t4_full_stall", host_a_ready, 1'b0);
    nxt();
    host_d_ready = 1'b1; clint_rsp(1'b1, 3'd1, 4'd0, 32'hA0); settle();
    chk("t4_full_dfire_stall", host_a_ready, 1'b0);
    chk("t4_d_source0", host_d_source, 4'd0);
    nxt();
    clint_rsp(1'b1, 3'd1, 4'd1, 32'hA1); settle();
    chk("t4_overlap_a_ready", host_a_ready, 1'b1);
    chk("t4_overlap_d_valid", host_d_valid, 1'b1);
    nxt();
    a_req(32'h0200_0044, 3'd4, 4'd5, 32'd0);
    host_d_ready = 1'b0; clint_rsp(1'b0, 3'd0, '0, '0); settle();
    chk("t4_refill_ready", host_a_ready, 1'b1);
    nxt();
    a_req(32'h0200_0048, 3'd4, 4'd6, 32'd0); settle();
    chk("t4_full_again_stall", host_a_ready, 1'b0);
    host_a_valid = 1'b0;
    for (int i = 2; i < 6; i++) begin
      nxt();
      host_d_ready = 1'b1; clint_rsp(1'b1, 3'd1, 4'(i), 32'hA0 + 32'(i)); settle();
      chk("t4_drain_source", host_d_source, 4'(i));
    end
    nxt();
    clint_rsp(1'b0, 3'd0, '0, '0); settle();
    chk("t4_drained", host_d_valid, 1'b0);

    // target switch waits for the CLINT response; stray periph D is held off
    a_req(32'h0200_0100, 3'd4, 4'd1, 32'd0); settle();
    chk("t5_clint_ready", host_a_ready, 1'b1);
    nxt();
    a_req(32'h1000_0020, 3'd0, 4'd2, 32'h77);
    periph_rsp(1'b1, 3'd0, 4'hF, 32'd0); settle();
    chk("t5_switch_stall", host_a_ready, 1'b0);
    chk("t5_periph_a_valid", periph_a_valid, 1'b0);
    chk("t5_stray_d_ready", periph_d_ready, 1'b0);
    chk("t5_stray_d_valid", host_d_valid, 1'b0);
    nxt();
    periph_rsp(1'b0, 3'd0, '0, '0);
    clint_rsp(1'b1, 3'd1, 4'd1, 32'hC1); settle();
    chk("t5_clint_first", host_d_source, 4'd1);
    chk("t5_stall_on_dfire", host_a_ready, 1'b0);
    nxt();
    clint_rsp(1'b0, 3'd0, '0, '0); settle();
    chk("t5_periph_accepted", host_a_ready, 1'b1);
    nxt();
    host_a_valid = 1'b0;
    periph_rsp(1'b1, 3'd0, 4'd2, 32'd0); settle();
    chk("t5_periph_second", host_d_source, 4'd2);
    nxt();
    periph_rsp(1'b0, 3'd0, '0, '0);

    // reset with CLINT requests in flight
    host_d_ready = 1'b0;
    a_req(32'h0200_0000, 3'd4, 4'd1, 32'd0);
    nxt();
    a_req(32'h0200_0004, 3'd4, 4'd2, 32'd0);
    nxt();
    host_a_valid = 1'b0; rst = 1'b1;
    nxt();
    rst = 1'b0; host_d_ready = 1'b1;
    clint_rsp(1'b1, 3'd1, 4'd1, 32'hBAD); settle();
    chk("t6_d_valid_after_rst", host_d_valid, 1'b0);
    chk("t6_clint_d_ready_after_rst", clint_d_ready, 1'b0);
    a_req(32'h1000_0000, 3'd0, 4'd3, 32'd1); settle();
    chk("t6_periph_accepted", host_a_ready, 1'b1);
    nxt();
    host_a_valid = 1'b0; clint_rsp(1'b0, 3'd0, '0, '0);
    periph_rsp(1'b1, 3'd0, 4'd3, 32'd0); settle();
    chk("t6_periph_d_valid", host_d_valid, 1'b1);
    nxt();
    periph_rsp(1'b0, 3'd0, '0, '0);

    // reset with an error response pending
    host_d_ready = 1'b0;
    a_req(32'h4000_0000, 3'd4, 4'd4, 32'd0);
    nxt();
    host_a_valid = 1'b0; rst = 1'b1;
    nxt();
    rst = 1'b0;
    a_req(32'h4000_0000, 3'd4, 4'd3, 32'd0); settle();
    chk("t6_err_accepted", host_a_ready, 1'b1);
    chk("t6_err_d_idle", host_d_valid, 1'b0);
    nxt();
    host_a_valid = 1'b0; host_d_ready = 1'b1; settle();
    chk("t6_err_source", host_d_source, 4'd3);
    nxt();
    nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
